// File: rtl/ifu_align_predec.sv
// Fetch aligner/predecoder: buffers 16-bit parcels from fetch packets, re-aligns
// mixed RV32I/RVC streams and presents up to NI predecoded instructions per cycle.
module ifu_align_predec #(
    parameter int FW    = 2,
    parameter int NI    = 2,
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [31:0]       fetch_pc,
    input  logic [FW*32-1:0]  fetch_data,
    output logic [NI-1:0]     dec_valid,
    input  logic              dec_ready,
    output logic [NI*32-1:0]  dec_instr,
    output logic [NI*32-1:0]  dec_pc,
    output logic [NI-1:0]     dec_comp,
    output logic [NI-1:0]     dec_br,
    output logic [NI-1:0]     dec_jal,
    output logic [NI-1:0]     dec_jalr,
    output logic [NI*32-1:0]  dec_jimm
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = 2 * FW;

    logic [15:0]   buf_q [DEPTH];
    logic [15:0]   buf_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head_pc_q, head_pc_d;

    logic [CW:0]   slot_off [NI+1];
    logic [NI-1:0] slot_v;
    logic [31:0]   slot_ins [NI];
    logic [CW:0]   pop_len;
    logic          push, pop;
    logic [CW-1:0] n_push;

    logic unused_pc0;
    assign unused_pc0 = fetch_pc[0];

    // Slot k begins where slot k-1 ended; a slot is valid only if every halfword is buffered.
    always_comb begin
        logic [AW-1:0] idx0;
        logic [AW-1:0] idx1;
        logic          prev_v;
        logic          is_long;
        idx0        = '0;
        idx1        = '0;
        prev_v      = 1'b1;
        is_long     = 1'b0;
        pop_len     = '0;
        slot_off[0] = '0;
        for (int k = 0; k < NI; k++) begin
            idx0          = head_q + slot_off[k][AW-1:0];
            idx1          = idx0 + AW'(1);
            is_long       = (buf_q[idx0][1:0] == 2'b11);
            slot_off[k+1] = slot_off[k] + (is_long ? (CW+1)'(2) : (CW+1)'(1));
            slot_ins[k]   = is_long ? {buf_q[idx1], buf_q[idx0]} : {16'h0000, buf_q[idx0]};
            slot_v[k]     = prev_v && (slot_off[k+1] <= {1'b0, count_q});
            prev_v        = slot_v[k];
            if (slot_v[k]) begin
                pop_len = slot_off[k+1];
            end
        end
    end

    always_comb begin
        logic [31:0] ins;
        logic [2:0]  f3;
        logic [1:0]  quad;
        ins       = '0;
        f3        = '0;
        quad      = '0;
        dec_valid = slot_v;
        dec_instr = '0;
        dec_pc    = '0;
        dec_comp  = '0;
        dec_br    = '0;
        dec_jal   = '0;
        dec_jalr  = '0;
        dec_jimm  = '0;
        for (int k = 0; k < NI; k++) begin
            ins  = slot_ins[k];
            f3   = ins[15:13];
            quad = ins[1:0];
            dec_instr[k*32 +: 32] = ins;
            dec_pc[k*32 +: 32]    = head_pc_q + 32'({slot_off[k], 1'b0});
            dec_comp[k]           = (quad != 2'b11);
            if (quad != 2'b11) begin
                dec_br[k]   = (quad == 2'b01) && (f3[2:1] == 2'b11);
                dec_jal[k]  = (quad == 2'b01) && ((f3 == 3'b101) || (f3 == 3'b001));
                dec_jalr[k] = (quad == 2'b10) && (f3 == 3'b100) &&
                              (ins[11:7] != 5'd0) && (ins[6:2] == 5'd0);
                if (dec_jal[k]) begin
                    dec_jimm[k*32 +: 32] = {{20{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6],
                                            ins[7], ins[2], ins[11], ins[5:3], 1'b0};
                end
            end else begin
                dec_br[k]   = (ins[6:0] == 7'b1100011);
                dec_jal[k]  = (ins[6:0] == 7'b1101111);
                dec_jalr[k] = (ins[6:0] == 7'b1100111);
                if (dec_jal[k]) begin
                    dec_jimm[k*32 +: 32] = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                                            ins[30:21], 1'b0};
                end
            end
        end
    end

    // Ready is judged on the pre-pop count, so a same-cycle pop never makes room.
    assign fetch_ready = (count_q <= CW'(DEPTH - PW));
    assign push        = fetch_valid && fetch_ready && !flush;
    assign pop         = dec_ready && slot_v[0] && !flush;
    assign n_push      = fetch_pc[1] ? CW'(PW - 1) : CW'(PW);

    always_comb begin
        logic [AW-1:0] wr_idx;
        wr_idx    = '0;
        buf_d     = buf_q;
        head_d    = head_q;
        count_d   = count_q;
        head_pc_d = head_pc_q;
        if (push) begin
            for (int h = 0; h < PW; h++) begin
                if (!(h == 0 && fetch_pc[1])) begin
                    wr_idx        = head_q + count_q[AW-1:0] + AW'(h) - AW'(fetch_pc[1]);
                    buf_d[wr_idx] = fetch_data[h*16 +: 16];
                end
            end
        end
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + (push ? n_push : '0) - (pop ? CW'(pop_len) : '0);
            if (pop) begin
                head_d    = head_q + AW'(pop_len);
                head_pc_d = head_pc_q + 32'({pop_len, 1'b0});
            end
            if (push && count_q == '0) begin
                head_pc_d = {fetch_pc[31:1], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            count_q   <= '0;
            head_pc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
            buf_q     <= buf_d;
        end
    end
endmodule

// File: tb/tb_ifu_align_predec.sv
// Bench for ifu_align_predec: directed scenarios plus random sequential streams,
// checked against a parcel-queue reference model.
module tb_ifu_align_predec;
    localparam int FW = 2, NI = 2, DEPTH = 8, PW = 2 * FW;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, fetch_valid = 1'b0, dec_ready = 1'b0;
    logic fetch_ready;
    logic [31:0] fetch_pc = '0;
    logic [FW*32-1:0] fetch_data = '0;
    logic [NI-1:0] dec_valid, dec_comp, dec_br, dec_jal, dec_jalr;
    logic [NI*32-1:0] dec_instr, dec_pc, dec_jimm;

    int n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    ifu_align_predec #(.FW(FW), .NI(NI), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_data(fetch_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_comp(dec_comp),
        .dec_br(dec_br), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_jimm(dec_jimm)
    );

    typedef struct {
        logic [15:0] hw;
        logic [31:0] pc;
    } parcel_t;
    parcel_t mq[$];

    bit          last_push;
    bit          exp_v[NI];
    logic [31:0] exp_ins[NI];
    logic [31:0] exp_pc[NI];
    int          exp_pop;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Predecode straight from the ISA field definitions, immediates built arithmetically.
    function automatic void ref_pd(input logic [31:0] ins, output bit br, output bit jal,
                                   output bit jalr, output logic [31:0] jimm);
        int v, f3, quad, op;
        f3 = int'(ins[15:13]); quad = int'(ins[1:0]); op = int'(ins[6:0]);
        v = 0; br = 0; jal = 0; jalr = 0;
        if (quad == 3) begin
            br = (op == 99); jal = (op == 111); jalr = (op == 103);
            if (jal) begin
                v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12) +
                    int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2;
                if (ins[31]) v = v - (1 << 21);
            end
        end else begin
            br   = (quad == 1) && (f3 == 6 || f3 == 7);
            jal  = (quad == 1) && (f3 == 5 || f3 == 1);
            jalr = (quad == 2) && (f3 == 4) && (ins[11:7] != 0) && (ins[6:2] == 0);
            if (jal) begin
                v = int'(ins[12]) * 2048 + int'(ins[8]) * 1024 + int'(ins[10:9]) * 256 +
                    int'(ins[6]) * 128 + int'(ins[7]) * 64 + int'(ins[2]) * 32 +
                    int'(ins[11]) * 16 + int'(ins[5:3]) * 2;
                if (ins[12]) v = v - 4096;
            end
        end
        jimm = v;
    endfunction

    function automatic void model_eval();
        int  idx;
        bit  prev;
        int  len;
        idx = 0; prev = 1; exp_pop = 0;
        for (int k = 0; k < NI; k++) begin
            exp_v[k] = 0; exp_ins[k] = '0; exp_pc[k] = '0;
            if (prev && idx < mq.size()) begin
                len = (mq[idx].hw[1:0] == 2'b11) ? 2 : 1;
                if (idx + len <= mq.size()) begin
                    exp_v[k]   = 1;
                    exp_pc[k]  = mq[idx].pc;
                    exp_ins[k] = (len == 2) ? {mq[idx+1].hw, mq[idx].hw} : {16'h0000, mq[idx].hw};
                    idx        = idx + len;
                    exp_pop    = idx;
                end
            end
            prev = exp_v[k];
        end
    endfunction

    // One clock: check outputs at negedge, then advance the model over the edge.
    task automatic step();
        bit fr, push, pop, br, jal, jalr;
        logic [31:0] jimm;
        logic [NI-1:0] ev;
        @(negedge clk);
        model_eval();
        fr = (mq.size() <= DEPTH - PW);
        chk("fetch_ready", fetch_ready, fr);
        for (int k = 0; k < NI; k++) ev[k] = exp_v[k];
        chk("dec_valid", dec_valid, ev);
        for (int k = 0; k < NI; k++) begin
            if (exp_v[k]) begin
                ref_pd(exp_ins[k], br, jal, jalr, jimm);
                chk($sformatf("s%0d_instr", k), dec_instr[k*32 +: 32], exp_ins[k]);
                chk($sformatf("s%0d_pc", k), dec_pc[k*32 +: 32], exp_pc[k]);
                chk($sformatf("s%0d_comp", k), dec_comp[k], exp_ins[k][1:0] != 2'b11);
                chk($sformatf("s%0d_br", k), dec_br[k], br);
                chk($sformatf("s%0d_jal", k), dec_jal[k], jal);
                chk($sformatf("s%0d_jalr", k), dec_jalr[k], jalr);
                chk($sformatf("s%0d_jimm", k), dec_jimm[k*32 +: 32], jimm);
            end
        end
        push = fetch_valid && fr && !flush;
        pop  = dec_ready && exp_v[0] && !flush;
        @(posedge clk);
        last_push = push;
        if (flush) begin
            mq.delete();
        end else begin
            if (push && mq.size() > 0)
                assert ({fetch_pc[31:1], 1'b0} == mq[$].pc + 32'd2)
                else $error("non-sequential fetch packet at 0x%08h", fetch_pc);
            if (pop) repeat (exp_pop) void'(mq.pop_front());
            if (push) begin
                for (int h = int'(fetch_pc[1]); h < PW; h++)
                    mq.push_back('{fetch_data[h*16 +: 16], {fetch_pc[31:2], 2'b00} + 32'(2 * h)});
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] pool[8];
        pool = '{32'h0080006F, 32'hFF9FF0EF, 32'h00008067, 32'hFE000EE3,
                 32'h4501A001, 32'h8082C111, 32'h2811B7FD, 32'h90829002};
        if ($urandom_range(0, 1) == 1) return pool[$urandom_range(0, 7)];
        return $urandom;
    endfunction

    function automatic logic [31:0] rand_pc();
        return ($urandom & 32'h0FFF_FFFC) | (32'($urandom_range(0, 1)) << 1);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pend;
        bit got;
        logic [31:0] npc;

        // Reset
        #1;
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_fetch_ready", fetch_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_dec_valid", dec_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        // Aligned 32-bit pair
        fetch_valid = 1; fetch_pc = 32'h1000; fetch_data = {32'h0080006F, 32'h00100093}; dec_ready = 1;
        step();
        fetch_valid = 0;
        chk("al_valid", dec_valid, 2'b11);
        chk("al_pc0", dec_pc[31:0], 32'h1000);
        chk("al_instr0", dec_instr[31:0], 32'h00100093);
        chk("al_comp0", dec_comp[0], 0);
        chk("al_pc1", dec_pc[63:32], 32'h1004);
        chk("al_jal1", dec_jal[1], 1);
        chk("al_jimm1", dec_jimm[63:32], 32'h8);
        step();

        // RVC mix
        fetch_valid = 1; fetch_pc = 32'h1000; fetch_data = {32'h8082C111, 32'h4501A001};
        step();
        fetch_valid = 0;
        chk("rvc_instr0", dec_instr[31:0], 32'h0000A001);
        chk("rvc_jal0", dec_jal[0], 1);
        chk("rvc_comp0", dec_comp[0], 1);
        chk("rvc_jimm0", dec_jimm[31:0], 0);
        chk("rvc_instr1", dec_instr[63:32], 32'h00004501);
        chk("rvc_pc1", dec_pc[63:32], 32'h1002);
        chk("rvc_flags1", {dec_br[1], dec_jal[1], dec_jalr[1]}, 0);
        step();
        chk("rvc_w1_valid", dec_valid, 2'b11);
        chk("rvc_w1_pc0", dec_pc[31:0], 32'h1004);
        chk("rvc_w1_br0", dec_br[0], 1);
        chk("rvc_w1_jalr1", dec_jalr[1], 1);
        step();

        // Straddling 32-bit instruction
        fetch_valid = 1; fetch_pc = 32'h1002; fetch_data = {32'h00934501, 32'h4501BEEF};
        step();
        fetch_valid = 0;
        chk("st_valid", dec_valid, 2'b11);
        chk("st_pc0", dec_pc[31:0], 32'h1002);
        chk("st_pc1", dec_pc[63:32], 32'h1004);
        step();
        chk("st_partial_valid", dec_valid, 2'b00);
        fetch_valid = 1; fetch_pc = 32'h1008; fetch_data = {32'h00000013, 32'h45050010};
        step();
        fetch_valid = 0;
        chk("st_instr0", dec_instr[31:0], 32'h00100093);
        chk("st_pc0b", dec_pc[31:0], 32'h1006);
        chk("st_comp0", dec_comp[0], 0);
        for (int i = 0; i < 4 && mq.size() > 0; i++) step();

        // Backpressure
        dec_ready = 0; fetch_valid = 1; fetch_data = {32'h45054501, 32'h45034501};
        fetch_pc = 32'h3000; step();
        fetch_pc = 32'h3008; step();
        chk("bp_full_ready", fetch_ready, 0);
        fetch_pc = 32'h3010; fetch_data = {32'h45114513, 32'h45154517};
        step();
        chk("bp_held1", last_push, 0);
        step();
        chk("bp_held2", last_push, 0);
        dec_ready = 1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = last_push;
        end
        chk("bp_third_accepted", got, 1);
        fetch_valid = 0;
        for (int i = 0; i < 10 && mq.size() > 0; i++) step();
        chk("bp_drained", mq.size(), 0);

        // Flush collision
        dec_ready = 0; fetch_valid = 1; fetch_pc = 32'h1000; fetch_data = {32'h00100093, 32'h4501A001};
        step();
        flush = 1; fetch_pc = 32'h1008; dec_ready = 1;
        step();
        flush = 0; fetch_valid = 0;
        chk("fl_valid", dec_valid, 0);
        chk("fl_ready", fetch_ready, 1);
        fetch_valid = 1; fetch_pc = 32'h2000; fetch_data = {32'h00000013, 32'h00100093}; dec_ready = 0;
        step();
        fetch_valid = 0;
        chk("fl_pc0", dec_pc[31:0], 32'h2000);
        chk("fl_valid0", dec_valid[0], 1);
        step();

        // Reset mid-stream
        rst_n = 0;
        #1;
        chk("mrst_dec_valid", dec_valid, 0);
        chk("mrst_fetch_ready", fetch_ready, 1);
        mq.delete();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        step();

        // Random sequential streams with flushes and backpressure
        pend = 0;
        npc = rand_pc();
        for (int c = 0; c < 3000; c++) begin
            flush = ($urandom_range(0, 99) < 3);
            if (!pend && $urandom_range(0, 99) < 75) begin
                fetch_pc = npc;
                for (int w = 0; w < FW; w++) fetch_data[w*32 +: 32] = rand_word();
                npc = {npc[31:2], 2'b00} + 32'(4 * FW);
                pend = 1;
            end
            fetch_valid = pend;
            dec_ready = ($urandom_range(0, 99) < 60);
            step();
            if (flush) begin
                pend = 0;
                npc = rand_pc();
            end else if (last_push) begin
                pend = 0;
            end
        end
        flush = 0; fetch_valid = 0; dec_ready = 1;
        for (int i = 0; i < 10; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ifu_align_predec.md
Name: ifu_align_predec

Overview:
- Parametrised fetch aligner and predecoder between the fetch-packet source and decode.
- Buffers 16-bit parcels from FW-word fetch packets and re-aligns mixed RV32I/RVC streams, including 32-bit instructions that straddle packet boundaries.
- Presents up to NI predecoded instructions per cycle: comp, br, jal, jalr, jal immediate, PC.
- Adds registered buffering, valid/ready handshakes and flush handling on top of the purely combinational per-word predecode.

Parameters:
- FW, 2, 32-bit words per fetch packet (≥1).
- NI, 2, instruction slots presented per cycle (≥1).
- DEPTH, 8, parcel buffer depth in halfwords; power of two, ≥ 2*FW and ≥ 2*NI.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous redirect; discards all buffered parcels
- fetch_valid  in  1  fetch packet valid
- fetch_ready  out  1  packet accepted when fetch_valid & fetch_ready
- fetch_pc  in  32  packet PC; bit0 ignored; bit1=1 drops the first halfword
- fetch_data  in  FW*32  packet; halfword h at fetch_data[h*16+:16], address fetch_pc[31:2]*4 + 2h
- dec_valid  out  NI  thermometer-coded slot valid (slot k valid ⇒ slots <k valid)
- dec_ready  in  1  consumer takes all valid slots this cycle
- dec_instr  out  NI*32  slot instruction; compressed forms zero-extended from 16 bits
- dec_pc  out  NI*32  slot PC
- dec_comp  out  NI  instr[1:0] != 2'b11
- dec_br  out  NI  conditional branch
- dec_jal  out  NI  direct jump
- dec_jalr  out  NI  indirect jump
- dec_jimm  out  NI*32  sign-extended jump offset

Behaviour:
- Storage: circular buffer of DEPTH halfwords with head pointer, count (log2(DEPTH)+1 bits), and head_pc register.
- Reset (async, rst_n=0):
  - count=0, head=0, head_pc=0.
  - dec_valid=0, fetch_ready=1.
  - All other dec_* outputs are don't-care while dec_valid is 0.
  - Reset mid-stream discards all parcels.
- Push:
  - Enqueues n = 2*FW - fetch_pc[1] halfwords in address order.
  - fetch_ready = (count ≤ DEPTH - 2*FW), evaluated on the pre-pop count. This is conservative: a simultaneous pop does not make room the same cycle.
  - If count==0 at push, head_pc <= fetch_pc & ~1.
  - Otherwise the packet must be sequential to the buffer tail. Non-sequential packets without a flush are a source protocol error, flagged by a bench assertion.
- Slot formation (combinational from registered buffer state):
  - Slot 0 starts at head. Length is 1 halfword if the low bits != 11, else 2.
  - Slot k starts after slot k-1.
  - Slot k is valid iff slot k-1 is valid and all its halfwords are within count.
  - A 32-bit instruction with only its low half buffered is not valid. It stays at head until the next packet supplies the high half.
- Latency: a packet accepted at edge N is visible on dec_* after edge N, i.e. in cycle N+1. There is no combinational fetch→dec path.
- Pop: when dec_ready and dec_valid[0], consume all valid slots.
  - head += total halfwords consumed; count updated as count + pushed − popped.
  - head_pc += 2*halfwords consumed.
  - dec_pc[k] = head_pc + 2*offset_k (mod 2^32).
- Pointer arithmetic wraps mod DEPTH.
- Simultaneous push and pop in one cycle is legal and both take effect.
- flush:
  - Next-state count=0; any push or pop in the same cycle is discarded.
  - dec_valid=0 the following cycle.
  - fetch_ready stays per formula (1 after flush).
- Predecode per slot:
  - br: 32-bit opcode 1100011, or C.BEQZ/C.BNEZ (q01, funct3 110/111).
  - jal: opcode 1101111, or C.J (q01, f3 101), or C.JAL (q01, f3 001).
  - jalr: opcode 1100111, or C.JR/C.JALR (q10, f3 100, rs1≠0, rs2=0).
  - dec_jimm: J-type immediate for 32-bit jal, CJ immediate for C.J/C.JAL, both sign-extended to 32 bits; 0 when jal=0.
- Flag outputs of invalid slots are don't-care. Bench compares only valid slots.

Test Plan (FW=2, NI=2, DEPTH=8):
1. Reset: rst_n=0 then 1 → dec_valid=00 and fetch_ready=1 through reset; also assert rst_n low mid-stream → dec_valid=00 immediately.
2. Aligned 32-bit: pc=0x1000, data {0x0080006F, 0x00100093}, dec_ready=1 → next cycle:
   - dec_valid=11.
   - slot0 pc 0x1000, instr 0x00100093, comp=0.
   - slot1 pc 0x1004, jal=1, jimm=0x00000008.
3. RVC mix: pc=0x1000, word0=0x4501A001 → next cycle:
   - slot0 instr 0x0000A001, jal=1, comp=1, jimm=0.
   - slot1 0x00004501 at 0x1002, br/jal/jalr=0.
   - After the pop, the two word1 halfwords present at head_pc=0x1004.
4. Straddle: pc=0x1002, data {0x00934501, 0x4501xxxx}, dec_ready=1 →
   - c.li at 0x1002 and 0x1004 present; slot0 then holds 0x0093 alone → dec_valid=00.
   - Push pc=0x1008 word0 low=0x0010 → next cycle slot0 instr 0x00100093, pc 0x1006, comp=0.
5. Backpressure: dec_ready=0, push two full packets → count=8 and fetch_ready=0. Third packet held stable, not accepted. Raise dec_ready → slots drain in address order with no loss or duplication, and the third packet is accepted once count ≤4.
6. Flush collision: flush=1 with fetch_valid=1 and dec_ready=1 in the same cycle → next cycle dec_valid=00, packet dropped. Then push pc=0x2000 → slot0 pc 0x2000.
